// File: rtl/tube_scan_driver_pkg.sv
// rtl/tube_scan_driver_pkg.sv - segment codes, digit count and select helper for the scan driver
package tube_scan_driver_pkg;

   localparam int TUBE_BITS   = 8;
   localparam int SCAN_DIGITS = 8;
   localparam int IDX_W       = $clog2(SCAN_DIGITS);

   typedef logic [TUBE_BITS-1:0] seg_t;
   typedef logic [IDX_W-1:0]     idx_t;

   // Common-anode codes, dp in bit 7: a segment is lit when its bit is 0.
   localparam seg_t SEG_ZERO  = 8'hC0;
   localparam seg_t SEG_ONE   = 8'hF9;
   localparam seg_t SEG_TWO   = 8'hA4;
   localparam seg_t SEG_THREE = 8'hB0;
   localparam seg_t SEG_FOUR  = 8'h99;
   localparam seg_t SEG_FIVE  = 8'h92;
   localparam seg_t SEG_SIX   = 8'h82;
   localparam seg_t SEG_SEVEN = 8'hF8;
   localparam seg_t SEG_EIGHT = 8'h80;
   localparam seg_t SEG_NINE  = 8'h90;
   localparam seg_t SEG_EMP   = 8'hFF;

   function automatic logic [SCAN_DIGITS-1:0] digit_sel(input idx_t idx);
      logic [SCAN_DIGITS-1:0] sel;
      sel      = '0;
      sel[idx] = 1'b1;
      return sel;
   endfunction

endpackage

// File: rtl/tube_scan_driver_tick_divider.sv
// rtl/tube_scan_driver_tick_divider.sv - free-running divider, tick high on the last count of each DIV-clock period
module tick_divider #(
   parameter int DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   output logic tick
);

   localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      tick  = (cnt_q == LAST);
      cnt_d = tick ? '0 : cnt_q + CW'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: rtl/tube_scan_driver.sv
// rtl/tube_scan_driver.sv - 8-digit seven-segment scan driver with frame snapshot,
// leading-zero blanking, per-digit blink and anti-ghost dead time
module tube_scan_driver
   import tube_scan_driver_pkg::*;
#(
   parameter int CLK_HZ   = 100000000,
   parameter int SCAN_HZ  = 1000,
   parameter int BLINK_HZ = 2,
   parameter int DEAD_CYC = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [TUBE_BITS-1:0]   l0,
   input  logic [TUBE_BITS-1:0]   l1,
   input  logic [TUBE_BITS-1:0]   l2,
   input  logic [TUBE_BITS-1:0]   l3,
   input  logic [TUBE_BITS-1:0]   l4,
   input  logic [TUBE_BITS-1:0]   l5,
   input  logic [TUBE_BITS-1:0]   l6,
   input  logic [TUBE_BITS-1:0]   l7,
   input  logic                   blank_lz,
   input  logic [SCAN_DIGITS-1:0] blink_mask,
   output logic [SCAN_DIGITS-1:0] tube_sel,
   output logic [TUBE_BITS-1:0]   seg_out
);

   localparam int            SCAN_DIV  = CLK_HZ / SCAN_HZ;
   localparam int            BLINK_DIV = CLK_HZ / (2 * BLINK_HZ);
   localparam int            DW        = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
   localparam logic [DW-1:0] DEAD_MAX  = DW'(DEAD_CYC);

   logic slot_tick, blink_tick;

   tick_divider #(.DIV(SCAN_DIV)) u_slot_div (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (slot_tick)
   );

   tick_divider #(.DIV(BLINK_DIV)) u_blink_div (
      .clk  (clk),
      .rst_n(rst_n),
      .tick (blink_tick)
   );

   idx_t                   idx_q, idx_d;
   logic [DW-1:0]          dead_q, dead_d;
   logic                   phase_q, phase_d;
   logic                   load_pend_q, load_pend_d;
   seg_t                   shadow_q [SCAN_DIGITS];
   seg_t                   shadow_d [SCAN_DIGITS];
   seg_t                   l_in     [SCAN_DIGITS];
   logic [SCAN_DIGITS-1:0] sel_q, sel_d;
   seg_t                   seg_q, seg_d;

   logic                   frame_end;
   logic                   in_dead;
   logic                   lz_run;
   logic [SCAN_DIGITS-1:0] blanked;
   logic                   show;

   always_comb begin
      l_in[0] = l0;  l_in[1] = l1;  l_in[2] = l2;  l_in[3] = l3;
      l_in[4] = l4;  l_in[5] = l5;  l_in[6] = l6;  l_in[7] = l7;

      frame_end   = slot_tick && (idx_q == idx_t'(SCAN_DIGITS - 1));
      idx_d       = slot_tick ? idx_q + idx_t'(1) : idx_q;
      phase_d     = phase_q ^ blink_tick;
      load_pend_d = 1'b0;
      shadow_d    = (load_pend_q || frame_end) ? l_in : shadow_q;

      // dead_q mirrors the slot count, saturated at DEAD_CYC
      in_dead = (dead_q < DEAD_MAX);
      if (slot_tick)    dead_d = '0;
      else if (in_dead) dead_d = dead_q + DW'(1);
      else              dead_d = dead_q;

      lz_run  = 1'b1;
      blanked = '0;
      for (int k = SCAN_DIGITS - 1; k >= 0; k--) begin
         lz_run     = lz_run && (shadow_q[k] == SEG_ZERO);
         blanked[k] = blank_lz && lz_run && (k != 0);
      end

      show  = !in_dead && !blanked[idx_q] && !(phase_q && blink_mask[idx_q]);
      sel_d = show ? digit_sel(idx_q) : '0;
      seg_d = show ? shadow_q[idx_q] : SEG_EMP;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q       <= '0;
         dead_q      <= '0;
         phase_q     <= 1'b0;
         load_pend_q <= 1'b1;
         for (int k = 0; k < SCAN_DIGITS; k++) shadow_q[k] <= SEG_EMP;
         sel_q       <= '0;
         seg_q       <= SEG_EMP;
      end else begin
         idx_q       <= idx_d;
         dead_q      <= dead_d;
         phase_q     <= phase_d;
         load_pend_q <= load_pend_d;
         shadow_q    <= shadow_d;
         sel_q       <= sel_d;
         seg_q       <= seg_d;
      end
   end

   assign tube_sel = sel_q;
   assign seg_out  = seg_q;

endmodule

// File: tb/tb_tube_scan_driver.sv
// tb/tb_tube_scan_driver.sv - directed table and sequence checks for tube_scan_driver
module tb_tube_scan_driver;
   import tube_scan_driver_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   seg_t       l [SCAN_DIGITS];
   logic       blank_lz;
   logic [7:0] blink_mask;
   logic [7:0] tube_sel;
   seg_t       seg_out;

   int errors = 0;
   int checks = 0;
   int ec     = 0;

   always #5 clk = ~clk;

   tube_scan_driver #(
      .CLK_HZ(1000), .SCAN_HZ(100), .BLINK_HZ(5), .DEAD_CYC(2)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .l0(l[0]), .l1(l[1]), .l2(l[2]), .l3(l[3]),
      .l4(l[4]), .l5(l[5]), .l6(l[6]), .l7(l[7]),
      .blank_lz(blank_lz), .blink_mask(blink_mask),
      .tube_sel(tube_sel), .seg_out(seg_out)
   );

   typedef struct {
      int         at;
      logic [7:0] sel;
      seg_t       seg;
   } vec_t;

   vec_t s1 [13];

   task automatic chk(input string nm, input logic [7:0] es, input seg_t eg);
      checks++;
      if (tube_sel !== es || seg_out !== eg) begin
         errors++;
         $display("FAIL %s edge %0d: tube_sel=%h seg_out=%h, expected tube_sel=%h seg_out=%h",
                  nm, ec, tube_sel, seg_out, es, eg);
      end
   endtask

   task automatic step();
      @(posedge clk);
      ec++;
      @(negedge clk);
   endtask

   task automatic goto(input int e);
      while (ec < e) step();
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      repeat (n) @(negedge clk);
      rst_n = 1'b1;
      ec    = 0;
   endtask

   task automatic set_basic();
      l[0] = SEG_ONE;
      for (int k = 1; k < SCAN_DIGITS; k++) l[k] = SEG_TWO;
      blank_lz   = 1'b0;
      blink_mask = 8'h00;
   endtask

   task automatic run_s1(input string nm);
      for (int i = 0; i < 13; i++) begin
         goto(s1[i].at);
         chk(nm, s1[i].sel, s1[i].seg);
      end
   endtask

   initial begin
      int         ph, slot;
      logic [7:0] es;
      seg_t       eg;

      // edge n = nth rising edge after reset release; first slot's 2 dead clocks are edges 1-2
      s1[0]  = '{1,  8'h00, SEG_EMP};
      s1[1]  = '{2,  8'h00, SEG_EMP};
      s1[2]  = '{3,  8'h01, SEG_ONE};
      s1[3]  = '{10, 8'h01, SEG_ONE};
      s1[4]  = '{11, 8'h00, SEG_EMP};
      s1[5]  = '{12, 8'h00, SEG_EMP};
      s1[6]  = '{13, 8'h02, SEG_TWO};
      s1[7]  = '{20, 8'h02, SEG_TWO};
      s1[8]  = '{21, 8'h00, SEG_EMP};
      s1[9]  = '{23, 8'h04, SEG_TWO};
      s1[10] = '{73, 8'h80, SEG_TWO};
      s1[11] = '{81, 8'h00, SEG_EMP};
      s1[12] = '{83, 8'h01, SEG_ONE};

      rst_n = 1'b0;
      set_basic();
      repeat (2) @(negedge clk);
      chk("reset_state", 8'h00, SEG_EMP);
      do_reset(1);

      run_s1("first_frame");

      for (int e = 84; e <= 240; e++) begin
         step();
         ph   = (ec - 1) % 10;
         slot = ((ec - 1) / 10) % 8;
         es   = (ph >= 2) ? (8'h01 << slot) : 8'h00;
         eg   = (ph >= 2) ? ((slot == 0) ? SEG_ONE : SEG_TWO) : SEG_EMP;
         chk("scan_seq", es, eg);
         checks++;
         if ($countones(tube_sel) > 1) begin
            errors++;
            $display("FAIL onehot edge %0d: tube_sel=%h, expected at most one bit", ec, tube_sel);
         end
      end

      set_basic();
      do_reset(2);
      goto(15);
      l[3] = SEG_NINE;
      goto(35);  chk("snap_old", 8'h08, SEG_TWO);
      goto(38);  chk("snap_old", 8'h08, SEG_TWO);
      goto(115); chk("snap_new", 8'h08, SEG_NINE);
      goto(118); chk("snap_new", 8'h08, SEG_NINE);

      set_basic();
      blank_lz = 1'b1;
      for (int k = 0; k < SCAN_DIGITS; k++) l[k] = SEG_ZERO;
      l[2] = SEG_ONE;
      do_reset(2);
      goto(5);  chk("lz_d0", 8'h01, SEG_ZERO);
      goto(15); chk("lz_d1", 8'h02, SEG_ZERO);
      goto(25); chk("lz_d2", 8'h04, SEG_ONE);
      for (int s = 3; s < 8; s++) begin
         goto(s * 10 + 5);
         chk("lz_blank", 8'h00, SEG_EMP);
      end
      goto(85);
      l[2] = SEG_ZERO;
      goto(165); chk("lz_all_d0", 8'h01, SEG_ZERO);
      for (int s = 1; s < 8; s++) begin
         goto(160 + s * 10 + 5);
         chk("lz_all_blank", 8'h00, SEG_EMP);
      end
      blank_lz = 1'b0;
      goto(245); chk("lz_off_d0", 8'h01, SEG_ZERO);
      goto(275); chk("lz_off_d3", 8'h08, SEG_ZERO);
      goto(315); chk("lz_off_d7", 8'h80, SEG_ZERO);

      set_basic();
      blink_mask = 8'h01;
      do_reset(2);
      goto(5);   chk("blink_on",  8'h01, SEG_ONE);
      goto(85);  chk("blink_on",  8'h01, SEG_ONE);
      goto(90);  chk("blink_on",  8'h01, SEG_ONE);
      goto(165); chk("blink_off", 8'h00, SEG_EMP);
      goto(170); chk("blink_off", 8'h00, SEG_EMP);
      goto(175); chk("blink_d1",  8'h02, SEG_TWO);
      goto(245); chk("blink_back", 8'h01, SEG_ONE);

      set_basic();
      do_reset(2);
      goto(55);
      chk("pre_reset_d5", 8'h20, SEG_TWO);
      rst_n = 1'b0;
      #1;
      chk("async_reset", 8'h00, SEG_EMP);
      repeat (3) @(negedge clk);
      chk("held_reset", 8'h00, SEG_EMP);
      rst_n = 1'b1;
      ec    = 0;
      run_s1("restart");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
